elbeth_dp_memory: RTL and testbench
===================================

Name: elbeth_dp_memory

Overview:
- Synchronous dual-port 32-bit word memory shared by the elbeth core.
- Port A serves instruction fetch; port B serves data load/store.
- Both ports are symmetric and independent.
- Each port has enable, a byte-lane write mask and a one-cycle ready handshake.

Parameters:
- ADDR_WIDTH, 8, word-address width; depth = 2**ADDR_WIDTH words (default 256 words = 1 KiB).
- DATA_WIDTH, 32, word width; must be 32 (four byte lanes).
- INIT_FILE, "memory.hex", hex image used when ELBETH_MEM_INIT_EN is defined.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets).
- amem_enable  in  1  port A access request this cycle.
- amem_addr  in  ADDR_WIDTH  port A word address (not byte address).
- amem_data_in  in  32  port A write data.
- amem_rw  in  4  port A byte write mask; bit i writes bits [8i+7:8i]; 4'b0000 = read.
- amem_data_out  out  32  port A read data.
- amem_ready  out  1  port A access complete / data_out valid.
- bmem_enable, bmem_addr, bmem_data_in, bmem_rw, bmem_data_out, bmem_ready: identical to port A, for port B.

Behaviour:
- Reset (rst=0 at a rising edge):
  - x_data_out <= 0 and x_ready <= 0 on both ports.
  - Memory array contents are not cleared.
- Access acceptance:
  - An access is accepted on any rising edge with rst=1 and x_enable=1.
  - No back-pressure; every accepted access completes.
- Latency and ready:
  - x_ready=1 in exactly the cycle after acceptance.
  - x_ready=0 in the cycle after any edge with x_enable=0.
  - Continuous enable gives one access per cycle with ready high every cycle (fully pipelined).
- Read (rw=0000):
  - x_data_out <= mem[addr] at the accepting edge.
- Write (rw!=0000):
  - Only masked byte lanes of mem[addr] are updated at the accepting edge.
  - x_data_out returns the pre-write word (read-first).
- Hold:
  - When x_enable=0, x_data_out holds its last value; only ready drops.
- Cross-port, same address, same edge:
  - A read concurrent with a write on the other port returns the old word.
  - Both ports writing: per byte lane, port B wins where both masks set; each port's unique lanes are both written.
- Addresses use all ADDR_WIDTH bits with no wrap or error logic; every address is valid.
- Reset mid-operation:
  - An access presented in the reset cycle is dropped: no write, no ready.
  - Operation resumes on the first edge with rst=1.
- Unknown (X) inputs are not required to be handled.

Optional Feature:
- Macro: ELBETH_MEM_INIT_EN.
- Defined: the array is preloaded at time zero from INIT_FILE (hex, one 32-bit word per line, starting at address 0). Unlisted words are 0.
- Undefined: the array is initialised to all zeros at time zero. INIT_FILE is ignored.
- Runtime behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with amem_enable=1 -> amem_ready=0, bmem_ready=0, both data_out=0. A write attempted during reset leaves the word unchanged.
- Port B full write then port A read: B writes 0xDEADBEEF to addr 0x10 with rw=1111; next cycle A reads addr 0x10 -> amem_ready=1 one cycle later, amem_data_out=0xDEADBEEF.
- Byte mask: addr 0x20 holds 0x11223344; B writes 0xAABBCCDD with rw=0101 -> subsequent read returns 0x11BB33DD. bmem_data_out during the write cycle = 0x11223344.
- Pipelined reads: A enable held high over addrs 0,1,2,3 preloaded 0xA0..0xA3 -> ready high 4 consecutive cycles, data 0xA0,0xA1,0xA2,0xA3 each one cycle after its address.
- Collision: addr 0x30 = 0; same edge A writes 0x0000FFFF rw=0011 and B writes 0x12345678 rw=0110 -> word = 0x003456FF.
- Init: with ELBETH_MEM_INIT_EN and an image whose first word is 0x00000013 -> read of addr 0 returns 0x00000013. Without the macro -> returns 0.

Source files
------------

// File: rtl/elbeth_mem_image.svh
`ifndef ELBETH_MEM_IMAGE_SVH
`define ELBETH_MEM_IMAGE_SVH
`define ELBETH_MEM_IMAGE '{0: 32'h00000013, default: '0}
`endif

// File: rtl/elbeth_dp_memory.sv
// elbeth_dp_memory
//   Dual-port word memory shared by the elbeth core. Port A serves
//   instruction fetch and port B serves data load/store. The two ports are
//   symmetric, fully pipelined and independent.
//
//   Each port has a one-cycle latency and byte-lane write masks. Reads
//   return the word as it was before any write on the same edge.
//   When both ports write the same word, port B wins each byte lane that
//   both masks select.
//
//   Optional feature: when the macro ELBETH_MEM_INIT_EN is defined, the
//   array is preloaded from the bundled hex image (one word per entry,
//   starting at address 0). Otherwise the array starts as all zeros.
//
//   Ports:
//     clk                    clock, rising edge
//     rst                    synchronous reset, active low
//     amem_enable            port A access request this cycle
//     amem_addr              port A word address
//     amem_data_in           port A write data
//     amem_rw                port A byte write mask (0000 = read)
//     amem_data_out          port A read data (pre-write word on writes)
//     amem_ready             port A access completed in the previous cycle
//     bmem_*                 identical set for port B
`include "elbeth_mem_image.svh"
module elbeth_dp_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter     INIT_FILE  = "memory.hex"
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    amem_enable,
    input  logic [ADDR_WIDTH-1:0]   amem_addr,
    input  logic [DATA_WIDTH-1:0]   amem_data_in,
    input  logic [DATA_WIDTH/8-1:0] amem_rw,
    output logic [DATA_WIDTH-1:0]   amem_data_out,
    output logic                    amem_ready,

    input  logic                    bmem_enable,
    input  logic [ADDR_WIDTH-1:0]   bmem_addr,
    input  logic [DATA_WIDTH-1:0]   bmem_data_in,
    input  logic [DATA_WIDTH/8-1:0] bmem_rw,
    output logic [DATA_WIDTH-1:0]   bmem_data_out,
    output logic                    bmem_ready
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NLANES = DATA_WIDTH / 8;

`ifdef ELBETH_MEM_INIT_EN
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = `ELBETH_MEM_IMAGE;
`else
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
`endif

    logic                  a_rdy_q, b_rdy_q;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    logic [NLANES-1:0]     a_we, b_we;

    // Accesses presented while reset is asserted are dropped entirely.
    always_comb begin
        a_we     = '0;
        b_we     = '0;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        if (rst && amem_enable) begin
            a_we     = amem_rw;
            a_data_d = mem_q[amem_addr];
        end
        if (rst && bmem_enable) begin
            b_we     = bmem_rw;
            b_data_d = mem_q[bmem_addr];
        end
    end

    // Port B's lane update comes after port A's in the same block, so B takes
    // precedence on a shared lane of a shared word. Different words or lanes
    // are both written.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NLANES; l++) begin
            if (a_we[l]) mem_q[amem_addr][8*l +: 8] <= amem_data_in[8*l +: 8];
            if (b_we[l]) mem_q[bmem_addr][8*l +: 8] <= bmem_data_in[8*l +: 8];
        end
    end

    // The output registers sample the array before this edge's writes land,
    // which gives read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rdy_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            a_rdy_q  <= amem_enable;
            b_rdy_q  <= bmem_enable;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

    assign amem_ready    = a_rdy_q;
    assign amem_data_out = a_data_q;
    assign bmem_ready    = b_rdy_q;
    assign bmem_data_out = b_data_q;

endmodule

// File: tb/tb_elbeth_dp_memory.sv
// Directed bench for elbeth_dp_memory (default build: array starts at zero).
// Each table row is one clock: inputs are applied at the falling edge, and
// outputs are compared 1 ns after the following rising edge.
module tb_elbeth_dp_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        amem_enable, bmem_enable;
    logic [7:0]  amem_addr, bmem_addr;
    logic [31:0] amem_data_in, bmem_data_in;
    logic [3:0]  amem_rw, bmem_rw;
    logic [31:0] amem_data_out, bmem_data_out;
    logic        amem_ready, bmem_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elbeth_dp_memory dut (
        .clk          (clk),
        .rst          (rst),
        .amem_enable  (amem_enable),
        .amem_addr    (amem_addr),
        .amem_data_in (amem_data_in),
        .amem_rw      (amem_rw),
        .amem_data_out(amem_data_out),
        .amem_ready   (amem_ready),
        .bmem_enable  (bmem_enable),
        .bmem_addr    (bmem_addr),
        .bmem_data_in (bmem_data_in),
        .bmem_rw      (bmem_rw),
        .bmem_data_out(bmem_data_out),
        .bmem_ready   (bmem_ready)
    );

    typedef struct {
        logic        rst;
        logic        ae;
        logic [7:0]  aaddr;
        logic [31:0] adin;
        logic [3:0]  arw;
        logic        be;
        logic [7:0]  baddr;
        logic [31:0] bdin;
        logic [3:0]  brw;
        logic        x_ardy;
        logic [31:0] x_adout;
        logic        x_brdy;
        logic [31:0] x_bdout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r,
        input logic ae, input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] arw,
        input logic be, input logic [7:0] ba, input logic [31:0] bd, input logic [3:0] brw,
        input logic xar, input logic [31:0] xad, input logic xbr, input logic [31:0] xbd);
        vec_t v;
        v.rst = r;  v.ae = ae; v.aaddr = aa; v.adin = ad; v.arw = arw;
        v.be = be;  v.baddr = ba; v.bdin = bd; v.brw = brw;
        v.x_ardy = xar; v.x_adout = xad; v.x_brdy = xbr; v.x_bdout = xbd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r,
                         input logic ae, input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] arw,
                         input logic be, input logic [7:0] ba, input logic [31:0] bd, input logic [3:0] brw);
        @(negedge clk);
        rst = r;
        amem_enable = ae; amem_addr = aa; amem_data_in = ad; amem_rw = arw;
        bmem_enable = be; bmem_addr = ba; bmem_data_in = bd; bmem_rw = brw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        amem_enable = 1'b0; amem_addr = '0; amem_data_in = '0; amem_rw = '0;
        bmem_enable = 1'b0; bmem_addr = '0; bmem_data_in = '0; bmem_rw = '0;

        //               rst ae aaddr  adin          arw      be baddr  bdin          brw      ardy adout         brdy bdout
        // reset held 3 cycles with a port A write attempt
        vq.push_back(mk(0, 1, 8'h05, 32'hCAFEBABE, 4'b1111, 0, 8'h00, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0));
        vq.push_back(mk(0, 1, 8'h05, 32'hCAFEBABE, 4'b1111, 0, 8'h00, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0));
        vq.push_back(mk(0, 1, 8'h05, 32'hCAFEBABE, 4'b1111, 0, 8'h00, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0));
        // word 5 unchanged by the reset-time write; word 0 starts at zero
        vq.push_back(mk(1, 1, 8'h05, 32'h0,        4'b0000, 1, 8'h00, 32'h0,        4'b0000, 1, 32'h0,        1, 32'h0));
        // B full write, then A reads it back
        vq.push_back(mk(1, 0, 8'h00, 32'h0,        4'b0000, 1, 8'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0,        1, 32'h0));
        vq.push_back(mk(1, 1, 8'h10, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 0, 32'h0));
        // byte mask 0101 over 0x11223344
        vq.push_back(mk(1, 0, 8'h00, 32'h0,        4'b0000, 1, 8'h20, 32'h11223344, 4'b1111, 0, 32'hDEADBEEF, 1, 32'h0));
        vq.push_back(mk(1, 0, 8'h00, 32'h0,        4'b0000, 1, 8'h20, 32'hAABBCCDD, 4'b0101, 0, 32'hDEADBEEF, 1, 32'h11223344));
        vq.push_back(mk(1, 1, 8'h20, 32'h0,        4'b0000, 1, 8'h20, 32'h0,        4'b0000, 1, 32'h11BB33DD, 1, 32'h11BB33DD));
        // preload words 0..3 from both ports at once
        vq.push_back(mk(1, 1, 8'h00, 32'hA0,       4'b1111, 1, 8'h01, 32'hA1,       4'b1111, 1, 32'h0,        1, 32'h0));
        vq.push_back(mk(1, 1, 8'h02, 32'hA2,       4'b1111, 1, 8'h03, 32'hA3,       4'b1111, 1, 32'h0,        1, 32'h0));
        // pipelined reads on A; B idle holds data
        vq.push_back(mk(1, 1, 8'h00, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'hA0,       0, 32'h0));
        vq.push_back(mk(1, 1, 8'h01, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'hA1,       0, 32'h0));
        vq.push_back(mk(1, 1, 8'h02, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'hA2,       0, 32'h0));
        vq.push_back(mk(1, 1, 8'h03, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'hA3,       0, 32'h0));
        // same-word collision: A 0011, B 0110
        vq.push_back(mk(1, 1, 8'h30, 32'h0000FFFF, 4'b0011, 1, 8'h30, 32'h12345678, 4'b0110, 1, 32'h0,        1, 32'h0));
        vq.push_back(mk(1, 1, 8'h30, 32'h0,        4'b0000, 1, 8'h30, 32'h0,        4'b0000, 1, 32'h003456FF, 1, 32'h003456FF));
        // A writes while B reads the same word: B sees the old word
        vq.push_back(mk(1, 1, 8'h30, 32'h55555555, 4'b1111, 1, 8'h30, 32'h0,        4'b0000, 1, 32'h003456FF, 1, 32'h003456FF));
        vq.push_back(mk(1, 0, 8'h00, 32'h0,        4'b0000, 1, 8'h30, 32'h0,        4'b0000, 0, 32'h003456FF, 1, 32'h55555555));
        // top address, no aliasing onto word 0
        vq.push_back(mk(1, 1, 8'hFF, 32'h87654321, 4'b1111, 0, 8'h00, 32'h0,        4'b0000, 1, 32'h0,        0, 32'h55555555));
        vq.push_back(mk(1, 1, 8'hFF, 32'h0,        4'b0000, 1, 8'h00, 32'h0,        4'b0000, 1, 32'h87654321, 1, 32'hA0));
        // reset mid-operation drops a write to 0xFF
        vq.push_back(mk(0, 1, 8'hFF, 32'h0,        4'b1111, 1, 8'h00, 32'h0,        4'b0000, 0, 32'h0,        0, 32'h0));
        vq.push_back(mk(1, 1, 8'hFF, 32'h0,        4'b0000, 0, 8'h00, 32'h0,        4'b0000, 1, 32'h87654321, 0, 32'h0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ae, vq[i].aaddr, vq[i].adin, vq[i].arw,
                  vq[i].be, vq[i].baddr, vq[i].bdin, vq[i].brw);
            check($sformatf("v%0d amem_ready", i),    {31'b0, amem_ready}, {31'b0, vq[i].x_ardy});
            check($sformatf("v%0d amem_data_out", i), amem_data_out,       vq[i].x_adout);
            check($sformatf("v%0d bmem_ready", i),    {31'b0, bmem_ready}, {31'b0, vq[i].x_brdy});
            check($sformatf("v%0d bmem_data_out", i), bmem_data_out,       vq[i].x_bdout);
        end

        // Same-port write then immediate read of that word, followed by idle cycles.
        drive(1, 1, 8'h40, 32'h01020304, 4'b1111, 0, 8'h00, 32'h0, 4'b0000);
        check("seq_a wr ready", {31'b0, amem_ready}, 32'd1);
        check("seq_a wr old",   amem_data_out, 32'h0);
        drive(1, 1, 8'h40, 32'h0, 4'b0000, 0, 8'h00, 32'h0, 4'b0000);
        check("seq_a rd data",  amem_data_out, 32'h01020304);
        drive(1, 0, 8'h40, 32'hFFFFFFFF, 4'b1111, 0, 8'h00, 32'h0, 4'b0000);
        check("seq_a idle ready", {31'b0, amem_ready}, 32'd0);
        check("seq_a idle hold",  amem_data_out, 32'h01020304);
        drive(1, 0, 8'h00, 32'h0, 4'b0000, 0, 8'h00, 32'h0, 4'b0000);
        check("seq_a idle hold2", amem_data_out, 32'h01020304);

        // Single top-lane write from B, then read back from both ports.
        drive(1, 0, 8'h00, 32'h0, 4'b0000, 1, 8'h40, 32'hFF000000, 4'b1000);
        check("seq_b wr old", bmem_data_out, 32'h01020304);
        drive(1, 1, 8'h40, 32'h0, 4'b0000, 1, 8'h40, 32'h0, 4'b0000);
        check("seq_b rd b", bmem_data_out, 32'hFF020304);
        check("seq_b rd a", amem_data_out, 32'hFF020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
